// File: rtl/reg_pair_seq.sv
// Register-pair transfer sequencer: turns single pair commands (copy, exchange, inc/dec,
// load, read-back) into fixed multi-cycle sequences on the register-file port.
`timescale 1ns/1ps

module reg_pair_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [2:0]  cmd_dst_i,
    input  logic [2:0]  cmd_src_i,
    input  logic        cmd_wide_i,
    input  logic [15:0] cmd_imm_i,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] rsp_data_o,
    input  logic [15:0] rf_rdata_i,
    output logic        rf_write_en_o,
    output logic [15:0] rf_data_o,
    output logic [4:0]  rf_write_sel_o,
    output logic [4:0]  rf_read_sel_o,
    output logic [1:0]  rf_ext_op_o
);

    localparam logic [2:0] OpNop  = 3'b000;
    localparam logic [2:0] OpCopy = 3'b001;
    localparam logic [2:0] OpXchg = 3'b010;
    localparam logic [2:0] OpInx  = 3'b011;
    localparam logic [2:0] OpDcx  = 3'b100;
    localparam logic [2:0] OpInx2 = 3'b101;
    localparam logic [2:0] OpLoad = 3'b110;
    localparam logic [2:0] OpRead = 3'b111;

    localparam logic [1:0] ExtNone = 2'b00;
    localparam logic [1:0] ExtInc  = 2'b01;
    localparam logic [1:0] ExtDcr  = 2'b10;
    localparam logic [1:0] ExtInc2 = 2'b11;

    localparam logic [2:0] MaxPair = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StWrA,
        StWrB,
        StExt,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic        init_q;
    logic [2:0]  op_q, dst_q, src_q;
    logic        wide_q;
    logic [15:0] tmp_a_q;
    logic [15:0] rsp_q;
    logic        err_q, err_d;

    logic        rf_write_en_q, rf_write_en_d;
    logic [15:0] rf_data_q, rf_data_d;
    logic [4:0]  rf_write_sel_q, rf_write_sel_d;
    logic [4:0]  rf_read_sel_q, rf_read_sel_d;
    logic [1:0]  rf_ext_op_q, rf_ext_op_d;

    logic        accept;
    logic [2:0]  c_op, c_dst, c_src;
    logic        c_wide;
    logic        illegal;

    function automatic logic [4:0] pair_sel(input logic [2:0] pair);
        return {1'b1, pair, 1'b0};
    endfunction

    // Narrow accesses address the high (even) or low (odd) register of the pair.
    function automatic logic [4:0] reg_sel(input logic wide, input logic [2:0] pair,
                                           input logic lo);
        return wide ? {1'b1, pair, 1'b0} : {1'b0, pair, lo};
    endfunction

    assign cmd_ready_o = init_q & ((state_q == StIdle) | (state_q == StFin));
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign done_o      = (state_q == StFin);
    assign err_o       = err_q;
    assign rsp_data_o  = rsp_q;

    assign rf_write_en_o  = rf_write_en_q;
    assign rf_data_o      = rf_data_q;
    assign rf_write_sel_o = rf_write_sel_q;
    assign rf_read_sel_o  = rf_read_sel_q;
    assign rf_ext_op_o    = rf_ext_op_q;

    // Command in effect: the incoming one on an accept edge, otherwise the latched one.
    always_comb begin
        c_op   = accept ? cmd_op_i   : op_q;
        c_dst  = accept ? cmd_dst_i  : dst_q;
        c_src  = accept ? cmd_src_i  : src_q;
        c_wide = accept ? cmd_wide_i : wide_q;
        illegal = (c_op != OpNop) &&
                  ((c_dst > MaxPair) ||
                   (((c_op == OpCopy) || (c_op == OpXchg)) && (c_src > MaxPair)));
    end

    always_comb begin
        state_d        = state_q;
        rf_write_en_d  = 1'b0;
        rf_data_d      = 16'h0000;
        rf_write_sel_d = 5'd0;
        rf_read_sel_d  = 5'd0;
        rf_ext_op_d    = ExtNone;

        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (accept) begin
                    if (illegal || (c_op == OpNop)) begin
                        state_d = StFin;
                    end else begin
                        unique case (c_op)
                            OpInx, OpDcx, OpInx2: state_d = StExt;
                            OpLoad:               state_d = StWrA;
                            default:              state_d = StRdA;
                        endcase
                    end
                end
            end
            StRdA: begin
                if (op_q == OpXchg) begin
                    state_d = StRdB;
                end else if (op_q == OpCopy) begin
                    state_d = StWrA;
                end else begin
                    state_d = StFin;
                end
            end
            StRdB:        state_d = StWrA;
            StWrA:        state_d = (op_q == OpXchg) ? StWrB : StFin;
            StWrB, StExt: state_d = StFin;
            default:      state_d = StIdle;
        endcase

        // Only legal commands ever reach FIN through a multi-cycle path.
        err_d = (state_d == StFin) ? illegal : err_q;

        // rf_* are registered, so they are derived from the state being entered.
        case (state_d)
            StRdA: begin
                if (c_op == OpRead) begin
                    rf_read_sel_d = reg_sel(c_wide, c_dst, c_src[0]);
                end else if (c_op == OpCopy) begin
                    rf_read_sel_d = pair_sel(c_src);
                end else begin
                    rf_read_sel_d = pair_sel(c_dst);
                end
            end
            StRdB: rf_read_sel_d = pair_sel(c_src);
            StWrA: begin
                rf_write_en_d = 1'b1;
                if (c_op == OpLoad) begin
                    rf_data_d      = c_wide ? cmd_imm_i : {8'h00, cmd_imm_i[7:0]};
                    rf_write_sel_d = reg_sel(c_wide, c_dst, c_src[0]);
                end else begin
                    // Read data arriving this edge (COPY src, XCHG src) goes straight to dst.
                    rf_data_d      = rf_rdata_i;
                    rf_write_sel_d = pair_sel(c_dst);
                end
            end
            StWrB: begin
                rf_write_en_d  = 1'b1;
                rf_data_d      = tmp_a_q;
                rf_write_sel_d = pair_sel(c_src);
            end
            StExt: begin
                rf_write_sel_d = pair_sel(c_dst);
                if (c_op == OpInx) begin
                    rf_ext_op_d = ExtInc;
                end else if (c_op == OpDcx) begin
                    rf_ext_op_d = ExtDcr;
                end else begin
                    rf_ext_op_d = ExtInc2;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            init_q         <= 1'b0;
            op_q           <= OpNop;
            dst_q          <= 3'd0;
            src_q          <= 3'd0;
            wide_q         <= 1'b0;
            tmp_a_q        <= 16'h0000;
            rsp_q          <= 16'h0000;
            err_q          <= 1'b0;
            rf_write_en_q  <= 1'b0;
            rf_data_q      <= 16'h0000;
            rf_write_sel_q <= 5'd0;
            rf_read_sel_q  <= 5'd0;
            rf_ext_op_q    <= ExtNone;
        end else begin
            state_q        <= state_d;
            init_q         <= 1'b1;
            err_q          <= err_d;
            rf_write_en_q  <= rf_write_en_d;
            rf_data_q      <= rf_data_d;
            rf_write_sel_q <= rf_write_sel_d;
            rf_read_sel_q  <= rf_read_sel_d;
            rf_ext_op_q    <= rf_ext_op_d;
            if (accept) begin
                op_q   <= cmd_op_i;
                dst_q  <= cmd_dst_i;
                src_q  <= cmd_src_i;
                wide_q <= cmd_wide_i;
            end
            if (state_q == StRdA) begin
                tmp_a_q <= rf_rdata_i;
                if (op_q == OpRead) begin
                    rsp_q <= wide_q ? rf_rdata_i : {8'h00, rf_rdata_i[7:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_pair_seq.sv
// Bench for reg_pair_seq: a byte-wide register file model on the rf port, a table of
// directed vectors, hand-written reset sequences and random commands against a pair model.
`timescale 1ns/1ps

module tb_reg_pair_seq;

    localparam logic [2:0] OpNop  = 3'd0;
    localparam logic [2:0] OpCopy = 3'd1;
    localparam logic [2:0] OpXchg = 3'd2;
    localparam logic [2:0] OpInx  = 3'd3;
    localparam logic [2:0] OpDcx  = 3'd4;
    localparam logic [2:0] OpInx2 = 3'd5;
    localparam logic [2:0] OpLoad = 3'd6;
    localparam logic [2:0] OpRead = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0, cmd_dst = 3'd0, cmd_src = 3'd0;
    logic        cmd_wide = 1'b0;
    logic [15:0] cmd_imm = 16'h0;
    logic        done, err;
    logic [15:0] rsp_data;
    logic [15:0] rf_rdata = 16'h0;
    logic        rf_write_en;
    logic [15:0] rf_data;
    logic [4:0]  rf_write_sel, rf_read_sel;
    logic [1:0]  rf_ext_op;

    reg_pair_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_op_i      (cmd_op),
        .cmd_dst_i     (cmd_dst),
        .cmd_src_i     (cmd_src),
        .cmd_wide_i    (cmd_wide),
        .cmd_imm_i     (cmd_imm),
        .done_o        (done),
        .err_o         (err),
        .rsp_data_o    (rsp_data),
        .rf_rdata_i    (rf_rdata),
        .rf_write_en_o (rf_write_en),
        .rf_data_o     (rf_data),
        .rf_write_sel_o(rf_write_sel),
        .rf_read_sel_o (rf_read_sel),
        .rf_ext_op_o   (rf_ext_op)
    );

    always #5 clk = ~clk;

    // Register file model: bytes B C D E H L W Z SPH SPL PCH PCL, high byte at even index.
    logic [7:0]  rf [0:11];
    logic [3:0]  ws, rs;
    logic [15:0] cur_pair, ext_val;
    assign ws = rf_write_sel[3:0];
    assign rs = rf_read_sel[3:0];
    assign cur_pair = {rf[ws], rf[ws+1]};
    assign ext_val = cur_pair + ((rf_ext_op == 2'b01) ? 16'h0001 :
                                 (rf_ext_op == 2'b10) ? 16'hFFFF : 16'h0002);

    always @(posedge clk) begin
        if (rf_ext_op != 2'b00) begin
            rf[ws]   <= ext_val[15:8];
            rf[ws+1] <= ext_val[7:0];
        end else if (rf_write_en) begin
            if (rf_write_sel[4]) begin
                rf[ws]   <= rf_data[15:8];
                rf[ws+1] <= rf_data[7:0];
            end else begin
                rf[ws] <= rf_data[7:0];
            end
        end
    end

    always @(negedge clk) begin
        rf_rdata <= rf_read_sel[4] ? {rf[rs], rf[rs+1]} : {8'h00, rf[rs]};
    end

    int overlap = 0;
    always @(negedge clk) if (rf_write_en && (rf_ext_op != 2'b00)) overlap++;

    logic        rf_any;
    logic [47:0] outs;
    assign rf_any = rf_write_en | (|rf_data) | (|rf_write_sel) | (|rf_read_sel) | (|rf_ext_op);
    assign outs = {cmd_ready, done, err, rsp_data, rf_write_en, rf_data, rf_write_sel,
                   rf_read_sel, rf_ext_op};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pair-level reference: six 16-bit pairs, updated by the command semantics.
    logic [15:0] ref_pair [0:5];

    task automatic model_apply(input logic [2:0] op, input logic [2:0] dst,
                               input logic [2:0] src, input logic wide,
                               input logic [15:0] imm, output logic e,
                               output logic [15:0] rsp, output int lat);
        logic [15:0] t;
        e   = (op != OpNop) && ((dst > 5) || (((op == OpCopy) || (op == OpXchg)) && (src > 5)));
        rsp = 16'h0;
        lat = 1;
        if (!e && (op != OpNop)) begin
            case (op)
                OpCopy: begin ref_pair[dst] = ref_pair[src]; lat = 3; end
                OpXchg: begin
                    t = ref_pair[dst]; ref_pair[dst] = ref_pair[src]; ref_pair[src] = t; lat = 5;
                end
                OpInx:  begin ref_pair[dst] = ref_pair[dst] + 16'd1; lat = 2; end
                OpDcx:  begin ref_pair[dst] = ref_pair[dst] - 16'd1; lat = 2; end
                OpInx2: begin ref_pair[dst] = ref_pair[dst] + 16'd2; lat = 2; end
                OpLoad: begin
                    t = ref_pair[dst];
                    if (wide) t = imm;
                    else if (src[0]) t[7:0] = imm[7:0];
                    else t[15:8] = imm[7:0];
                    ref_pair[dst] = t;
                    lat = 2;
                end
                default: begin
                    t = ref_pair[dst];
                    rsp = wide ? t : (src[0] ? {8'h00, t[7:0]} : {8'h00, t[15:8]});
                    lat = 2;
                end
            endcase
        end
    endtask

    function automatic logic [95:0] pack_rf();
        logic [95:0] v;
        for (int p = 0; p < 6; p++) v[95-16*p -: 16] = {rf[2*p], rf[2*p+1]};
        return v;
    endfunction

    function automatic logic [95:0] pack_ref();
        logic [95:0] v;
        for (int p = 0; p < 6; p++) v[95-16*p -: 16] = ref_pair[p];
        return v;
    endfunction

    // Called 1 time unit after a rising edge; returns at the same phase of the done cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                           input logic wide, input logic [15:0] imm, output int lat,
                           output logic e, output logic [15:0] rsp, output logic quiet,
                           output logic fin_quiet);
        int guard;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_wide = wide; cmd_imm = imm;
        cmd_valid = 1'b1;
        quiet = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (rf_any) quiet = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (rf_any) quiet = 1'b0;
        fin_quiet = !rf_any;
        e = err;
        rsp = rsp_data;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic        wide;
        logic [15:0] imm;
        logic        exp_err;
        logic        chk_rsp;
        logic [15:0] exp_rsp;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [2:0] dst,
                                input logic [2:0] src, input logic wide,
                                input logic [15:0] imm, input logic e, input logic chk,
                                input logic [15:0] rsp, input int lat);
        vec_t v;
        v.op = op; v.dst = dst; v.src = src; v.wide = wide; v.imm = imm;
        v.exp_err = e; v.chk_rsp = chk; v.exp_rsp = rsp; v.exp_lat = lat;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic exec_checked(input string tag, input logic [2:0] op, input logic [2:0] dst,
                                input logic [2:0] src, input logic wide,
                                input logic [15:0] imm, input logic use_tbl,
                                input vec_t v);
        int          lat, m_lat;
        logic        e, m_e, quiet, fin_quiet;
        logic [15:0] rsp, m_rsp;
        model_apply(op, dst, src, wide, imm, m_e, m_rsp, m_lat);
        if (use_tbl) begin
            m_e = v.exp_err; m_rsp = v.exp_rsp; m_lat = v.exp_lat;
        end
        run_cmd(op, dst, src, wide, imm, lat, e, rsp, quiet, fin_quiet);
        check({tag, " latency"}, 96'(lat), 96'(m_lat));
        check({tag, " err"}, 96'(e), 96'(m_e));
        if (use_tbl ? v.chk_rsp : ((op == OpRead) && !m_e))
            check({tag, " rsp_data"}, 96'(rsp), 96'(m_rsp));
        if (m_e || (op == OpNop)) check({tag, " rf idle"}, 96'(quiet), 96'(1));
        check({tag, " rf zero in FIN"}, 96'(fin_quiet), 96'(1));
        check({tag, " regfile"}, pack_rf(), pack_ref());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t dummy;
        int   lat;
        logic e, q, fq;
        logic [15:0] rsp;
        dummy = mk(OpNop, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) rf[i] = 8'h00;
        for (int p = 0; p < 6; p++) ref_pair[p] = 16'h0000;

        vecs.push_back(mk(OpLoad, 2, 0, 1, 16'h1234, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 2, 0, 1, 16'h0,    0, 1, 16'h1234, 2));
        vecs.push_back(mk(OpLoad, 0, 0, 1, 16'hFFFF, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpInx,  0, 0, 1, 16'h0,    0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 0, 0, 1, 16'h0,    0, 1, 16'h0000, 2));
        vecs.push_back(mk(OpDcx,  0, 0, 1, 16'h0,    0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 0, 0, 1, 16'h0,    0, 1, 16'hFFFF, 2));
        vecs.push_back(mk(OpInx2, 0, 0, 1, 16'h0,    0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 0, 0, 1, 16'h0,    0, 1, 16'h0001, 2));
        vecs.push_back(mk(OpLoad, 1, 0, 1, 16'hBEEF, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpLoad, 2, 0, 1, 16'h1234, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpXchg, 2, 1, 1, 16'h0,    0, 0, 16'h0, 5));
        vecs.push_back(mk(OpRead, 2, 0, 1, 16'h0,    0, 1, 16'hBEEF, 2));
        vecs.push_back(mk(OpRead, 1, 0, 1, 16'h0,    0, 1, 16'h1234, 2));
        vecs.push_back(mk(OpLoad, 2, 0, 1, 16'h8000, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpCopy, 4, 2, 1, 16'h0,    0, 0, 16'h0, 3));
        vecs.push_back(mk(OpRead, 4, 0, 1, 16'h0,    0, 1, 16'h8000, 2));
        vecs.push_back(mk(OpRead, 2, 0, 1, 16'h0,    0, 1, 16'h8000, 2));
        vecs.push_back(mk(OpRead, 4, 1, 0, 16'h0,    0, 1, 16'h0000, 2));
        vecs.push_back(mk(OpRead, 4, 0, 0, 16'h0,    0, 1, 16'h0080, 2));
        vecs.push_back(mk(OpLoad, 0, 0, 1, 16'h1234, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpLoad, 0, 1, 0, 16'hA55A, 0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 0, 0, 1, 16'h0,    0, 1, 16'h125A, 2));
        vecs.push_back(mk(OpRead, 0, 0, 0, 16'h0,    0, 1, 16'h0012, 2));
        vecs.push_back(mk(OpInx,  7, 0, 1, 16'h0,    1, 0, 16'h0, 1));
        vecs.push_back(mk(OpNop,  0, 0, 0, 16'h0,    0, 0, 16'h0, 1));
        vecs.push_back(mk(OpCopy, 1, 6, 1, 16'h0,    1, 0, 16'h0, 1));
        vecs.push_back(mk(OpXchg, 1, 1, 1, 16'h0,    0, 0, 16'h0, 5));
        vecs.push_back(mk(OpRead, 1, 0, 1, 16'h0,    0, 1, 16'h1234, 2));
        vecs.push_back(mk(OpRead, 6, 0, 1, 16'h0,    1, 0, 16'h0, 1));
        vecs.push_back(mk(OpDcx,  5, 0, 1, 16'h0,    0, 0, 16'h0, 2));
        vecs.push_back(mk(OpRead, 5, 0, 1, 16'h0,    0, 1, 16'hFFFF, 2));

        // Power-on reset
        #3;
        check("reset outputs", 96'(outs), 96'(0));
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready low before first edge", 96'(cmd_ready), 96'(0));
        @(posedge clk); #1;
        check("ready after reset", 96'(cmd_ready), 96'(1));

        foreach (vecs[i]) begin
            exec_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].dst, vecs[i].src,
                         vecs[i].wide, vecs[i].imm, 1'b1, vecs[i]);
        end

        // Reset during RD_B of an exchange; a stray command while busy must be ignored.
        exec_checked("pre DE", OpLoad, 1, 0, 1, 16'h1111, 1'b0, dummy);
        exec_checked("pre HL", OpLoad, 2, 0, 1, 16'h2222, 1'b0, dummy);
        cmd_op = OpXchg; cmd_dst = 3'd2; cmd_src = 3'd1; cmd_wide = 1'b1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = OpLoad; cmd_dst = 3'd1; cmd_imm = 16'hDEAD;
        check("xchg RD_A read sel", 96'(rf_read_sel), 96'(5'b10100));
        @(posedge clk); #1;
        check("xchg RD_B read sel", 96'(rf_read_sel), 96'(5'b10010));
        rst_n = 1'b0;
        #1;
        check("mid-xchg reset outputs", 96'(outs), 96'(0));
        @(posedge clk); #1;
        check("held reset outputs", 96'(outs), 96'(0));
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready low after release", 96'(cmd_ready), 96'(0));
        @(posedge clk); #1;
        check("ready after release", 96'(cmd_ready), 96'(1));
        exec_checked("post DE", OpRead, 1, 0, 1, 16'h0, 1'b0, dummy);
        exec_checked("post HL", OpRead, 2, 0, 1, 16'h0, 1'b0, dummy);

        // Random commands against the pair model.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  op, dst, src;
            logic        wide;
            logic [15:0] imm;
            op   = 3'($urandom_range(0, 7));
            dst  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            src  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            wide = 1'($urandom_range(0, 1));
            imm  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
            exec_checked($sformatf("rnd%0d op%0d", n, op), op, dst, src, wide, imm, 1'b0, dummy);
        end

        check("write_en with ext_op", 96'(overlap), 96'(0));
        // Bench-only sanity: keep the helper path used.
        run_cmd(OpNop, 0, 0, 0, 16'h0, lat, e, rsp, q, fq);
        check("final nop err", 96'(e), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_pair_seq.md
# reg_pair_seq

Register-pair transfer sequencer for the nam85 datapath. It accepts single register-pair commands (copy, exchange, increment/decrement, immediate load, read-back) from the control unit. It executes each command as a fixed multi-cycle sequence on the register file's write/read/extended-op interface. It sits between the instruction sequencer and the register file, and it is the only block that drives that interface.

## Interface
Parameters:
- None. Register map is fixed: B=0 C=1 D=2 E=3 H=4 L=5 W=6 Z=7 SPH=8 SPL=9 PCH=10 PCL=11.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  000 NOP, 001 COPY, 010 XCHG, 011 INX, 100 DCX, 101 INX2, 110 LOAD, 111 READ
- cmd_dst  in  3  pair index: 0 BC, 1 DE, 2 HL, 3 WZ, 4 SP, 5 PC; 6–7 illegal
- cmd_src  in  3  source pair (COPY, XCHG); byte select in bit 0 for narrow LOAD/READ (0=high reg, 1=low reg)
- cmd_wide  in  1  1 = 16-bit pair, 0 = 8-bit single register (LOAD/READ only)
- cmd_imm  in  16  LOAD data; narrow LOAD uses [7:0]
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; illegal pair index
- rsp_data  out  16  READ result, valid with done; narrow READ zero-extended
- rf_write_en  out  1  register file write enable
- rf_data  out  16  register file write data
- rf_write_sel  out  5  {wide, reg index} for writes/ext ops (index = 2*pair, plus byte bit when narrow)
- rf_read_sel  out  5  {wide, reg index} for reads
- rf_ext_op  out  2  00 none, 01 INC, 10 DCR, 11 INC2

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, EXT, FIN.
- All rf_* outputs are registered and are 0 in IDLE and FIN.
- The register file gives ext_op priority over write_en. The block never asserts both in the same cycle.
- Accept occurs on a rising edge with cmd_valid & cmd_ready. cmd_ready is high only in IDLE and FIN, and the block latches the command on accept.
- NOP: FIN directly, done with err=0.
- Illegal dst, or illegal src for COPY/XCHG: no rf activity, FIN with err=1.
- INX/DCX/INX2: EXT drives rf_write_sel={1,2*dst} and rf_ext_op=01/10/11. The pair wraps modulo 2^16 (FFFF+1=0000, 0000-1=FFFF, FFFF+2=0001).
- LOAD: WR_A drives rf_write_en=1, rf_data=cmd_imm, rf_write_sel={wide,index}.
- READ: RD_A drives rf_read_sel. Register-file data is captured into rsp_data at the end of RD_A.
- COPY: RD_A reads src, capturing tmp_a. WR_A writes tmp_a to dst.
- XCHG: RD_A reads dst (tmp_a), RD_B reads src (tmp_b), WR_A writes tmp_b to dst, WR_B writes tmp_a to src. When src==dst the sequence is still legal and leaves data unchanged.
- FIN: done=1 for one cycle. err and rsp_data are held until the next done.

## Timing
- Register-file read data is valid half a cycle after rf_read_sel is presented (the file captures on the falling edge). The block samples it at the next rising edge, giving one-cycle read latency.
- Writes and ext ops commit at the rising edge ending the cycle in which they are driven.
- Latency from the accept edge to done high: NOP/illegal 1, INX/DCX/INX2/LOAD 2, READ 2, COPY 3, XCHG 5 cycles.
- Back-to-back: a command accepted in FIN starts the next cycle with no bubble.
- Reset (rst=0, any time, including mid-sequence):
  - Immediately returns to IDLE.
  - cmd_ready=0, done=0, err=0, rsp_data=0, all rf_* = 0.
  - cmd_ready rises on the first rising edge after rst returns high.
  - An interrupted XCHG leaves no partial write beyond those already committed.
- cmd_valid while cmd_ready=0 is ignored, with no queuing.

## Test plan
- Reset then LOAD wide HL=0x1234; READ wide HL -> done 2 cycles after each accept, rsp_data=0x1234, err=0.
- LOAD BC=0xFFFF; INX BC; READ BC -> 0x0000. DCX BC -> 0xFFFF. INX2 BC -> 0x0001. rf_write_en never high during ext ops.
- LOAD DE=0xBEEF, HL=0x1234; XCHG dst=HL src=DE -> done 5 cycles after accept, READ HL=0xBEEF, READ DE=0x1234.
- COPY dst=SP src=HL with HL=0x8000 -> SP=0x8000, HL unchanged. Narrow READ src bit0=1 of SP -> rsp_data=0x0000. Narrow LOAD C=0x5A leaves B unchanged.
- Illegal dst=7 on INX -> done 1 cycle after accept, err=1, all rf_* outputs 0 throughout.
- Pull rst low during RD_B of XCHG -> outputs 0 immediately, cmd_ready=0. After release, READ DE and HL return their pre-XCHG values.
